operand_fetcher: RTL

//   Feeds operand bytes into the CPU's 8-bit registers: it drives their load/data_in side.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/operand_fetcher_if.sv | 39 +++
 rtl/pc_counter.sv | 29 ++
 rtl/operand_fetcher.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared types and widths for the CPU front end
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int DEFAULT_ADDR_W    = 16;
    localparam int DEFAULT_DATA_W    = 8;
    localparam int MAX_OPERAND_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Decoder may present 3; the longest operand is MAX_OPERAND_BYTES.
    function automatic logic [1:0] clamp_count(input logic [1:0] count);
        return (count > 2'(MAX_OPERAND_BYTES)) ? 2'(MAX_OPERAND_BYTES) : count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetcher_if.sv
`default_nettype none
// ============================================================================
// operand_fetcher_if : decoder, memory bus and register-load signals of the fetcher
// Revision: 1.0
// ============================================================================
interface operand_fetcher_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              start;
    logic [1:0]        byte_count;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] pc_out;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              ld_lo;
    logic              ld_hi;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;

    modport master (
        input  start, byte_count, pc_load, pc_in, mem_ack, mem_rdata,
        output pc_out, mem_rd, mem_addr, ld_lo, ld_hi, data_out, busy, done
    );

    modport slave (
        output start, byte_count, pc_load, pc_in, mem_ack, mem_rdata,
        input  pc_out, mem_rd, mem_addr, ld_lo, ld_hi, data_out, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// pc_counter : program counter with synchronous load and increment
// Revision: 1.0
// ============================================================================
module pc_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             inc,
    input  wire logic [WIDTH-1:0] load_value,
    output logic      [WIDTH-1:0] pc
);

    // Load wins over increment; increment wraps naturally at 2**WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetcher.sv
`default_nettype none
// ============================================================================
// operand_fetcher : reads 0-2 operand bytes at PC and strobes them into registers
// Revision: 1.0
// ============================================================================
module operand_fetcher
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    operand_fetcher_if.master bus
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic              pc_ld;
    logic              pc_inc;
    logic              mem_rd;
    logic              busy;
    logic              done;
    logic              byte_idx;
    logic [1:0]        num_bytes;
    logic              last_byte;
    logic              ld_lo_q;
    logic              ld_hi_q;
    logic [DATA_W-1:0] data_q;

    pc_counter #(
        .WIDTH      (ADDR_W)
    ) u_pc_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_ld),
        .inc        (pc_inc),
        .load_value (bus.pc_in),
        .pc         (pc)
    );

    assign last_byte = (({1'b0, byte_idx} + 2'd1) == num_bytes);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        unique case (state)
            IDLE: begin
                pc_ld = bus.pc_load;
                if (bus.start) begin
                    state_next = (clamp_count(bus.byte_count) == 2'd0) ? DONE : READ;
                end
            end
            READ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
                if (bus.mem_ack) begin
                    pc_inc = 1'b1;
                    if (last_byte) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes and data are registered so they appear the cycle after the ack;
    // data_q returns to 0 whenever no strobe is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx  <= 1'b0;
            num_bytes <= 2'd0;
            ld_lo_q   <= 1'b0;
            ld_hi_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            ld_lo_q <= 1'b0;
            ld_hi_q <= 1'b0;
            data_q  <= '0;
            if (state == IDLE && bus.start) begin
                num_bytes <= clamp_count(bus.byte_count);
                byte_idx  <= 1'b0;
            end
            if (mem_rd && bus.mem_ack) begin
                data_q   <= bus.mem_rdata;
                ld_lo_q  <= ~byte_idx;
                ld_hi_q  <= byte_idx;
                byte_idx <= 1'b1;
            end
        end
    end

    assign bus.pc_out   = pc;
    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = mem_rd ? pc : '0;
    assign bus.ld_lo    = ld_lo_q;
    assign bus.ld_hi    = ld_hi_q;
    assign bus.data_out = data_q;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule
`default_nettype wire
